// File: rtl/seq_mult32_pkg.sv
// Shared definitions for the sequential 32x32 multiplier.
// Contents: FSM state encoding and the fixed iteration count.
package seq_mult32_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int unsigned ITER_COUNT = 32;

endpackage

// File: rtl/seq_mult32_if.sv
// Operand/result handshake bundle for seq_mult32.
//   in_valid/in_ready : operand handshake (a, b)
//   out_valid/out_ready : result handshake (product)
//   busy : iteration in progress
// The master modport is the requester; the slave modport is the multiplier.
interface seq_mult32_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] product;
    logic        busy;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, product, busy
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, product, busy
    );
endinterface

// File: rtl/ripple_adder32.sv
// 32-bit ripple-carry adder built from a chain of full adders.
// Ports:
//   x, y : addends
//   cin  : carry in
//   s    : sum
//   cout : carry out of bit 31
module ripple_adder32 (
    input  logic [31:0] x,
    input  logic [31:0] y,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);

    logic [32:0] c;

    assign c[0] = cin;

    for (genvar i = 0; i < 32; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end

    assign cout = c[32];

endmodule

// File: rtl/seq_mult32.sv
// Sequential unsigned 32x32->64 shift-and-add multiplier.
// Retires one multiplier bit per clock through a single ripple_adder32.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : seq_mult32_if slave (operand and result handshakes, busy)
module seq_mult32
    import seq_mult32_pkg::*;
(
    input logic           clk,
    input logic           rst_n,
    seq_mult32_if.slave   bus
);

    localparam logic [4:0] LAST_COUNT = 5'(ITER_COUNT - 1);

    state_t      state_q, state_d;
    logic [31:0] mcand_q, mcand_d;
    logic [63:0] acc_q, acc_d;
    logic [4:0]  count_q, count_d;

    logic [31:0] add_x, add_y, add_s;
    logic        add_cout;

    // Partial product is added into the upper half only; the lower half holds the
    // not-yet-consumed multiplier bits, which shift out as product bits shift in.
    assign add_x = acc_q[63:32];
    assign add_y = acc_q[0] ? mcand_q : 32'd0;

    ripple_adder32 u_adder (
        .x    (add_x),
        .y    (add_y),
        .cin  (1'b0),
        .s    (add_s),
        .cout (add_cout)
    );

    always_comb begin
        state_d = state_q;
        mcand_d = mcand_q;
        acc_d   = acc_q;
        count_d = count_q;
        unique case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    state_d = BUSY;
                    mcand_d = bus.a;
                    acc_d   = {32'd0, bus.b};
                    count_d = 5'd0;
                end
            end
            BUSY: begin
                acc_d   = {add_cout, add_s, acc_q[31:1]};
                count_d = count_q + 5'd1;
                if (count_q == LAST_COUNT) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            mcand_q <= 32'd0;
            acc_q   <= 64'd0;
            count_q <= 5'd0;
        end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            acc_q   <= acc_d;
            count_q <= count_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.busy      = (state_q == BUSY);
    assign bus.out_valid = (state_q == DONE);
    assign bus.product   = acc_q;

endmodule
